// File: rtl/eco_lane_pipe.sv
// Per-lane nibble function F(a,b) behind a STAGES-deep valid/ready pipeline,
// with a MISR signature and saturating counter over delivered results.
module eco_lane_pipe #(
  parameter int          LANES  = 2,
  parameter int          STAGES = 2,
  parameter int unsigned POLY   = 'h1D
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*LANES-1:0]   a,
  input  logic [4*LANES-1:0]   b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*LANES-1:0]   y,
  input  logic                 sig_clr,
  output logic [4*LANES-1:0]   sig,
  output logic [15:0]          count
);
  localparam int W = 4 * LANES;
  localparam logic [W-1:0] POLY_W = W'(POLY);

  function automatic logic [3:0] nib_f(input logic [3:0] an, input logic [3:0] bn);
    logic p, q, r, s, t, u, v;
    logic y0, y1, y2, y3;
    p  = bn[3] | an[0];
    q  = p & an[1];
    r  = an[2] & bn[2];
    s  = ~(bn[3] | ~(an[3] ^ bn[1]));
    t  = bn[1] & s;
    u  = bn[0] | an[1];
    v  = an[3] & bn[0];
    y0 = ~(u & q);
    y1 = ~(u ^ r) ^ ~(u & v);
    y2 = an[2] ^ t;
    y3 = ~(s | t);
    return {y3, y2, y1, y0};
  endfunction

  logic [W-1:0]      f_dat;
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] adv;
  logic [W-1:0]      dat [STAGES];
  logic              hs;

  always_comb begin
    f_dat = '0;
    for (int k = 0; k < LANES; k++) begin
      f_dat[4*k +: 4] = nib_f(a[4*k +: 4], b[4*k +: 4]);
    end
  end

  // A stage may load when it is empty or its contents move on downstream.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = ~vld[STAGES-1] | out_ready;
    for (int i = STAGES - 2; i >= 0; i--) begin
      adv[i] = ~vld[i] | adv[i+1];
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = vld[STAGES-1];
  assign y         = dat[STAGES-1];
  assign hs        = out_valid & out_ready;

  // Data only moves with a valid beat, so y holds its last result when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < STAGES; i++) begin
        dat[i] <= '0;
      end
    end else begin
      if (adv[0]) begin
        vld[0] <= in_valid;
        if (in_valid) begin
          dat[0] <= f_dat;
        end
      end
      for (int i = 1; i < STAGES; i++) begin
        if (adv[i]) begin
          vld[i] <= vld[i-1];
          if (vld[i-1]) begin
            dat[i] <= dat[i-1];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig   <= '0;
      count <= '0;
    end else if (sig_clr) begin
      sig   <= '0;
      count <= '0;
    end else if (hs) begin
      sig <= {sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY_W : '0) ^ y;
      if (count != 16'hFFFF) begin
        count <= count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_eco_lane_pipe.sv
// Directed checks of eco_lane_pipe: a LANES=2/STAGES=2 instance for flow control,
// MISR and reset, plus a LANES=1/STAGES=1 instance swept over all operand pairs.
module tb_eco_lane_pipe;
  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid, in_ready, out_valid, out_ready, sig_clr;
  logic [7:0]  a, b, y, sig;
  logic [15:0] count;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, sig_clr1;
  logic [3:0]  a1, b1, y1, sig1;
  logic [15:0] count1;

  int passed = 0;
  int checks = 0;

  always #5 clk = ~clk;

  eco_lane_pipe #(.LANES(2), .STAGES(2), .POLY('h1D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .sig_clr(sig_clr), .sig(sig), .count(count)
  );

  eco_lane_pipe #(.LANES(1), .STAGES(1), .POLY('h1D)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1), .y(y1),
    .sig_clr(sig_clr1), .sig(sig1), .count(count1)
  );

  // Reference F in reduced algebraic form.
  function automatic logic [3:0] model_f(input logic [3:0] an, input logic [3:0] bn);
    logic s, t, u, v, r;
    s = ~bn[3] & (an[3] ^ bn[1]);
    t = bn[1] & s;
    u = bn[0] | an[1];
    v = an[3] & bn[0];
    r = an[2] & bn[2];
    return {~s, an[2] ^ t, u ^ r ^ v, ~(an[1] & (bn[3] | an[0]))};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; out_ready = 0; sig_clr = 0; a = 0; b = 0;
    in_valid1 = 0; out_ready1 = 1; sig_clr1 = 0; a1 = 0; b1 = 0;
    tick; tick;
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_sig", sig, 0);
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_in_ready1", in_ready1, 1);
    rst = 1'b0;
    tick;

    // first beat: two cycles of latency
    in_valid = 1; out_ready = 1; a = 8'h00; b = 8'h00;
    tick;
    in_valid = 0;
    check("lat_not_early", out_valid, 0);
    tick;
    check("lat_valid", out_valid, 1);
    check("lat_y", y, 8'h99);
    tick;
    check("lat_drained", out_valid, 0);

    // lane independence, back to back
    in_valid = 1; a = 8'hF5; b = 8'hFA;
    tick;
    a = 8'hF0; b = 8'hF0;
    tick;
    in_valid = 0;
    check("lane_ed_valid", out_valid, 1);
    check("lane_ed", y, 8'hED);
    tick;
    check("lane_e9_valid", out_valid, 1);
    check("lane_e9", y, 8'hE9);
    tick;

    // backpressure: two accepts fill the pipe, third waits
    out_ready = 0; in_valid = 1; a = 8'h00; b = 8'h00;
    #1 check("bp_rdy0", in_ready, 1);
    tick;
    a = 8'hFF; b = 8'hFF;
    #1 check("bp_rdy1", in_ready, 1);
    tick;
    a = 8'h55; b = 8'hAA;
    #1 check("bp_full", in_ready, 0);
    tick;
    check("bp_still_full", in_ready, 0);
    check("bp_hold_y", y, 8'h99);
    out_ready = 1;
    #1 check("bp_rdy_release", in_ready, 1);
    tick;
    in_valid = 0;
    check("bp_y1", y, 8'hEE);
    tick;
    check("bp_y2", y, 8'hDD);
    check("bp_y2_valid", out_valid, 1);
    tick;
    check("bp_empty", out_valid, 0);

    // MISR
    sig_clr = 1;
    tick;
    sig_clr = 0;
    check("clr_sig", sig, 0);
    check("clr_count", count, 0);
    in_valid = 1; a = 8'h00; b = 8'h00;
    tick;
    a = 8'hFF; b = 8'hFF;
    tick;
    a = 8'h55; b = 8'hAA;
    tick;
    in_valid = 0;
    check("misr_sig1", sig, 8'h99);
    check("misr_cnt1", count, 1);
    tick;
    check("misr_sig2", sig, 8'hC1);
    check("misr_cnt2", count, 2);
    check("misr_third_vld", out_valid, 1);
    sig_clr = 1;
    tick;
    sig_clr = 0;
    check("misr_clr_wins_sig", sig, 0);
    check("misr_clr_wins_cnt", count, 0);
    check("misr_third_gone", out_valid, 0);

    // reset with beats in flight
    in_valid = 1; a = 8'h00; b = 8'h00;
    tick;
    in_valid = 0;
    tick;
    tick;
    check("pre_rst_sig", sig, 8'h99);
    out_ready = 0; in_valid = 1; a = 8'hFF; b = 8'hFF;
    tick;
    a = 8'h55; b = 8'hAA;
    tick;
    in_valid = 0;
    check("pre_rst_valid", out_valid, 1);
    rst = 1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_y", y, 0);
    check("mid_rst_sig", sig, 0);
    check("mid_rst_count", count, 0);
    tick;
    rst = 0;
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick;
      check("post_rst_no_stale", out_valid, 0);
    end

    // exhaustive single-lane sweep
    in_valid1 = 1;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v8;
      v8 = i[7:0];
      a1 = v8[7:4]; b1 = v8[3:0];
      tick;
      check("ex_valid", out_valid1, 1);
      check("ex_y", y1, model_f(v8[7:4], v8[3:0]));
    end
    in_valid1 = 0;
    tick;
    check("ex_count", count1, 256);
    check("ex_idle", out_valid1, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/eco_lane_pipe.md
# eco_lane_pipe

Parametrised, pipelined successor to the team's 4-bit gate-level ECO test cone. Each 4-bit lane evaluates the fixed nibble function F(a,b). LANES independent lanes share one valid/ready pipeline of STAGES register stages. A MISR signature register and a saturating result counter make golden-versus-revised netlists comparable after ECO with one register read.

## Interface
- LANES, 2, number of independent 4-bit lanes (≥1); data width W = 4*LANES
- STAGES, 2, pipeline register depth (1..4)
- POLY, 'h1D, MISR feedback polynomial (low W bits used)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat offered
- in_ready  out  1  pipeline can accept a beat
- a  in  W  lane operand A (lane k = a[4k+3:4k])
- b  in  W  lane operand B
- out_valid  out  1  result beat available
- out_ready  in  1  downstream accepts the result
- y  out  W  registered lane results
- sig_clr  in  1  synchronous clear of sig and count
- sig  out  W  MISR signature of accepted results
- count  out  16  number of accepted results, saturating

## Operation
- Nibble function F per lane (a0..a3, b0..b3 = lane bits):
  - p = b3|a0; q = p&a1; r = a2&b2
  - s = ~(b3 | ~(a3^b1)); t = b1&s
  - u = b0|a1; v = a3&b0
  - y0 = ~(u&q); y1 = ~(u^r) ^ ~(u&v); y2 = a2^t; y3 = ~(s|t)
- F is evaluated combinationally on a/b. Stage 1 registers the result together with its valid bit. Stages 2..STAGES shift the result and valid bit forward. y is taken from the last stage.
- Stage i advances when it is empty or when stage i+1 advances. The last stage advances on out_ready.
- in_ready = stage 1 empty OR stage 1 advances; it is combinational.
- An input is accepted when in_valid && in_ready. A beat leaves the pipeline when out_valid && out_ready.
- Stalled stages hold their data and valid bit. No beat is ever dropped or duplicated.
- On each output handshake, the signature updates as sig <= {sig[W-2:0],1'b0} ^ (sig[W-1] ? POLY : 0) ^ y, and count increments, saturating at 16'hFFFF.
- While sig_clr=1, sig and count are set to 0 on the next edge, even if a handshake occurs in the same cycle.
- sig_clr does not affect the pipeline.

## Timing
- Reset (asynchronous assert; release takes effect at the next clk edge):
  - all stage valid bits = 0, so out_valid = 0
  - y = 0, sig = 0, count = 0
  - in_ready = 1 during and after reset
- Latency: a beat accepted at edge N presents at y/out_valid after edge N+STAGES-1 and is visible in cycle N+STAGES, provided there is no stall.
- Throughput: one beat per cycle while out_ready is held 1.
- Capacity: STAGES beats are buffered when out_ready=0; in_ready drops once all stages are full.
- Simultaneous events:
  - When the pipeline is full, a single cycle with out_ready=1 and in_valid=1 both accepts and delivers a beat.
  - When sig_clr coincides with a handshake, the clear wins.
- Reset mid-operation discards all in-flight beats.
- count saturation: it stays at FFFF; sig keeps updating.

## Test plan
- LANES=2, STAGES=2 after reset: check out_valid=0, y=00, sig=00, count=0, in_ready=1.
  - Apply a=8'h00, b=8'h00, in_valid=1, out_ready=1 for 1 cycle.
  - Expect y=8'h99 with out_valid=1 exactly 2 cycles later.
- Lane independence: a=8'hF5, b=8'hFA.
  - Expect y=8'hED (lane1 F(F,F)=E, lane0 F(5,A)=D).
  - Then a=8'hF0, b=8'hF0 → y=8'hE9.
- Backpressure: hold out_ready=0 and stream 3 beats (0x00/0x00, 0xFF/0xFF, 0x55/0xAA).
  - in_ready must drop after 2 accepts.
  - Raise out_ready: y must be 99, EE, then DD in order, with no loss.
- MISR: pulse sig_clr, then deliver y=99 then y=EE.
  - Expect sig=99 then sig=C1, and count=2.
  - Assert sig_clr together with a third handshake: sig=00, count=0.
- Exhaustive: LANES=1, STAGES=1, all 256 a/b pairs back-to-back with out_ready=1.
  - Each y must match the F model one cycle after acceptance.
  - count must reach 256.
- Assert rst while 2 beats are in flight.
  - out_valid must drop immediately; y=0, sig=0, count=0.
  - No stale beat may appear after reset is released.
